rs_alu: RTL and testbench
=========================

RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 Parameter ENTRIES, default 8: number of reservation-station slots; power of two, 2..16.
REQ-002 Parameter TAG_W, default 4: width of reorder-buffer tags.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rdy  input  1  global enable; when low, all state and outputs SHALL hold.
REQ-006 flush  input  1  mispredict flush; discards every entry.
REQ-007 dispatch_valid  input  1  dispatch request this cycle.
REQ-008 dispatch_op  input  6  ALU operation code, carried to issue_op unmodified.
REQ-009 dispatch_vj / dispatch_vk  input  32 each  operand values; meaningful only when the matching _rdy bit is 1.
REQ-010 dispatch_qj / dispatch_qk  input  TAG_W each  producer ROB tags; meaningful only when the matching _rdy bit is 0.
REQ-011 dispatch_qj_rdy / dispatch_qk_rdy  input  1 each  1 = operand value present.
REQ-012 dispatch_pc, dispatch_imm  input  32 each  instruction PC and sign-extended immediate.
REQ-013 dispatch_dest  input  TAG_W  ROB tag of the result.
REQ-014 cdb_valid, cdb_tag, cdb_value  input  1 / TAG_W / 32  common-data-bus broadcast.
REQ-015 full  output  1  combinational; 1 when all ENTRIES slots are busy.
REQ-016 issue_valid  output  1  registered; 1 = issue_* holds an instruction for the ALU this cycle.
REQ-017 issue_op, issue_rs, issue_rt, issue_pc, issue_imm, issue_dest  output  6/32/32/32/32/TAG_W  registered; feed ALU op, rs, rt, pc, imm and the result tag.

Function
REQ-018 Each slot SHALL hold busy, op, vj, qj, rj, vk, qk, rk, pc, imm and dest.
REQ-019 Dispatch SHALL be accepted when dispatch_valid=1, full=0, flush=0 and rdy=1. It writes the lowest-index free slot at the edge.
REQ-020 A dispatch presented while full=1 SHALL be ignored with no state change; upstream must not dispatch when full=1.
REQ-021 Dispatch bypass: if cdb_valid=1 and cdb_tag equals a not-ready dispatch_qj or dispatch_qk in the same cycle, the slot SHALL store cdb_value and that operand's ready bit set to 1.
REQ-022 Wakeup: every busy slot with rj=0 and qj==cdb_tag while cdb_valid=1 SHALL latch vj=cdb_value and set rj=1 at the edge; the k side behaves identically and both may wake in one cycle.
REQ-023 Select: a slot is eligible when busy=1, rj=1 and rk=1 at the start of the cycle. The lowest-index eligible slot SHALL be issued at the edge.
REQ-024 At issue, the slot's busy bit is cleared and issue_valid=1 is registered with the slot's op, vj->issue_rs, vk->issue_rt, pc, imm and dest. If no slot is eligible, issue_valid SHALL be registered 0 and issue data held.
REQ-025 Latency: an operand-ready dispatch at edge E SHALL produce issue_valid at edge E+1 at the earliest. A CDB wakeup at edge E SHALL make the slot issuable at edge E+1; there is no same-cycle wakeup-and-issue.
REQ-026 At most one dispatch and one issue per cycle. A slot freed by issue at edge E SHALL be available for dispatch at edge E+1; full is computed from state before the edge.
REQ-027 Flush (rdy=1) SHALL clear all busy bits and register issue_valid=0 at the edge. Flush has priority over dispatch, wakeup and issue.
REQ-028 rdy=0 SHALL freeze all slots and outputs; CDB broadcasts during rdy=0 are lost.

Reset
REQ-029 rst=1 at an edge SHALL clear every busy bit, set issue_valid=0, zero all issue_* data, and so drive full=0. rst overrides flush, rdy and dispatch, including mid-operation.

Verification
REQ-030 Dispatch ADDI with vj=5, imm=7, both ready, at edge 1 -> issue_valid=1 at edge 2 with issue_rs=5, issue_imm=7, issue_dest=dispatch_dest.
REQ-031 Dispatch ADD with qj=3 not ready; CDB tag 3, value 0x10 at edge 4 -> no issue at edge 4; issue at edge 5 with issue_rs=0x10.
REQ-032 Dispatch with qk=2 while CDB broadcasts tag 2, value 0xAB in the same cycle -> issues next edge with issue_rt=0xAB.
REQ-033 Fill 8 slots, all waiting on tag 9 -> full=1 and a 9th dispatch is ignored. Broadcast tag 9 -> slots issue in index order 0..7 on consecutive edges; full=0 after the first issue.
REQ-034 Flush with 5 busy slots and a simultaneous dispatch -> next cycle: full=0, issue_valid=0, no slot busy, and the dispatched instruction is never issued.
REQ-035 Assert rst with 3 slots busy and issue_valid=1 -> issue_valid=0 and all issue_* data are zero after the edge; a CDB broadcast on the next cycle causes no issue.

Source files
------------

// File: rtl/rs_alu.sv
// rs_alu: ALU reservation station with CDB wakeup, dispatch-time CDB bypass and
// lowest-index select; one dispatch and one issue per cycle.
module rs_alu #(
    parameter int ENTRIES = 8,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             dispatch_valid,
    input  logic [5:0]       dispatch_op,
    input  logic [31:0]      dispatch_vj,
    input  logic [31:0]      dispatch_vk,
    input  logic [TAG_W-1:0] dispatch_qj,
    input  logic [TAG_W-1:0] dispatch_qk,
    input  logic             dispatch_qj_rdy,
    input  logic             dispatch_qk_rdy,
    input  logic [31:0]      dispatch_pc,
    input  logic [31:0]      dispatch_imm,
    input  logic [TAG_W-1:0] dispatch_dest,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    output logic             full,
    output logic             issue_valid,
    output logic [5:0]       issue_op,
    output logic [31:0]      issue_rs,
    output logic [31:0]      issue_rt,
    output logic [31:0]      issue_pc,
    output logic [31:0]      issue_imm,
    output logic [TAG_W-1:0] issue_dest
);
    localparam int IW = $clog2(ENTRIES);

    logic [ENTRIES-1:0] r_busy, r_rj, r_rk;
    logic [5:0]         r_op   [ENTRIES];
    logic [31:0]        r_vj   [ENTRIES];
    logic [31:0]        r_vk   [ENTRIES];
    logic [31:0]        r_pc   [ENTRIES];
    logic [31:0]        r_imm  [ENTRIES];
    logic [TAG_W-1:0]   r_qj   [ENTRIES];
    logic [TAG_W-1:0]   r_qk   [ENTRIES];
    logic [TAG_W-1:0]   r_dest [ENTRIES];

    logic [ENTRIES-1:0] w_elig;
    logic [IW-1:0]      w_sel, w_free;
    logic               w_any_elig, w_disp, w_bj, w_bk;

    assign full       = &r_busy;
    assign w_elig     = r_busy & r_rj & r_rk;
    assign w_any_elig = |w_elig;
    assign w_disp     = dispatch_valid && !full;
    assign w_bj       = !dispatch_qj_rdy && cdb_valid && cdb_tag == dispatch_qj;
    assign w_bk       = !dispatch_qk_rdy && cdb_valid && cdb_tag == dispatch_qk;

    // Scan downward so the last hit is the lowest index.
    always_comb begin
        w_sel  = '0;
        w_free = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_elig[i]) w_sel = IW'(i);
            if (!r_busy[i]) w_free = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= '0;
            issue_valid <= 1'b0;
            issue_op    <= '0;
            issue_rs    <= '0;
            issue_rt    <= '0;
            issue_pc    <= '0;
            issue_imm   <= '0;
            issue_dest  <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_busy      <= '0;
                issue_valid <= 1'b0;
            end else begin
                issue_valid <= w_any_elig;
                if (w_any_elig) begin
                    r_busy[w_sel] <= 1'b0;
                    issue_op      <= r_op[w_sel];
                    issue_rs      <= r_vj[w_sel];
                    issue_rt      <= r_vk[w_sel];
                    issue_pc      <= r_pc[w_sel];
                    issue_imm     <= r_imm[w_sel];
                    issue_dest    <= r_dest[w_sel];
                end
                for (int i = 0; i < ENTRIES; i++) begin
                    if (cdb_valid && r_busy[i] && !r_rj[i] && r_qj[i] == cdb_tag) begin
                        r_vj[i] <= cdb_value;
                        r_rj[i] <= 1'b1;
                    end
                    if (cdb_valid && r_busy[i] && !r_rk[i] && r_qk[i] == cdb_tag) begin
                        r_vk[i] <= cdb_value;
                        r_rk[i] <= 1'b1;
                    end
                end
                // The free slot is never the issuing slot, so these writes cannot collide.
                if (w_disp) begin
                    r_busy[w_free] <= 1'b1;
                    r_op[w_free]   <= dispatch_op;
                    r_vj[w_free]   <= w_bj ? cdb_value : dispatch_vj;
                    r_vk[w_free]   <= w_bk ? cdb_value : dispatch_vk;
                    r_rj[w_free]   <= dispatch_qj_rdy || w_bj;
                    r_rk[w_free]   <= dispatch_qk_rdy || w_bk;
                    r_qj[w_free]   <= dispatch_qj;
                    r_qk[w_free]   <= dispatch_qk;
                    r_pc[w_free]   <= dispatch_pc;
                    r_imm[w_free]  <= dispatch_imm;
                    r_dest[w_free] <= dispatch_dest;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: vector table, directed corner sequences and random lockstep against a slot-level model.
module tb_rs_alu;
    logic        clk = 1'b0;
    logic        rst, rdy, flush, dispatch_valid, dispatch_qj_rdy, dispatch_qk_rdy, cdb_valid;
    logic [5:0]  dispatch_op;
    logic [31:0] dispatch_vj, dispatch_vk, dispatch_pc, dispatch_imm, cdb_value;
    logic [3:0]  dispatch_qj, dispatch_qk, dispatch_dest, cdb_tag;
    logic        full, issue_valid;
    logic [5:0]  issue_op;
    logic [31:0] issue_rs, issue_rt, issue_pc, issue_imm;
    logic [3:0]  issue_dest;

    rs_alu #(.ENTRIES(8), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
        .dispatch_vj(dispatch_vj), .dispatch_vk(dispatch_vk),
        .dispatch_qj(dispatch_qj), .dispatch_qk(dispatch_qk),
        .dispatch_qj_rdy(dispatch_qj_rdy), .dispatch_qk_rdy(dispatch_qk_rdy),
        .dispatch_pc(dispatch_pc), .dispatch_imm(dispatch_imm), .dispatch_dest(dispatch_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .full(full), .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_pc(issue_pc),
        .issue_imm(issue_imm), .issue_dest(issue_dest)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rdy, fl, dv;
        logic [5:0] op;
        logic [31:0] vj;
        logic jr;
        logic [3:0] qj;
        logic [31:0] vk;
        logic kr;
        logic [3:0] qk, dest;
        logic [31:0] pc, imm;
        logic cv;
        logic [3:0] ct;
        logic [31:0] cval;
        logic e_full, e_iv;
        logic [5:0] e_op;
        logic [31:0] e_rs, e_rt, e_pc, e_imm;
        logic [3:0] e_dest;
    } vec_t;

    typedef struct packed {
        logic busy, rj, rk;
        logic [5:0] op;
        logic [31:0] vj, vk, pc, imm;
        logic [3:0] qj, qk, dest;
    } slot_t;

    int n_vec = 0, n_err = 0;
    vec_t t[21];
    slot_t ms[8];
    logic m_iv;
    logic [5:0] m_op;
    logic [31:0] m_rs, m_rt, m_pc, m_imm;
    logic [3:0] m_dest;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic vec_t idle();
        vec_t v;
        v = '0;
        v.rdy = 1'b1;
        return v;
    endfunction

    function automatic vec_t disp(logic [5:0] op, logic [31:0] vj, logic jr, logic [3:0] qj,
                                  logic [31:0] vk, logic kr, logic [3:0] qk, logic [3:0] dest,
                                  logic [31:0] pc, logic [31:0] imm);
        vec_t v;
        v = idle();
        v.dv = 1'b1; v.op = op; v.vj = vj; v.jr = jr; v.qj = qj; v.vk = vk; v.kr = kr;
        v.qk = qk; v.dest = dest; v.pc = pc; v.imm = imm;
        return v;
    endfunction

    function automatic vec_t bcast(vec_t v, logic [3:0] tag, logic [31:0] val);
        v.cv = 1'b1; v.ct = tag; v.cval = val;
        return v;
    endfunction

    function automatic vec_t ex(vec_t v, logic [5:0] op, logic [31:0] rs, logic [31:0] rt,
                                logic [31:0] pc, logic [31:0] imm, logic [3:0] dest);
        v.e_iv = 1'b1; v.e_op = op; v.e_rs = rs; v.e_rt = rt; v.e_pc = pc; v.e_imm = imm; v.e_dest = dest;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rdy = v.rdy; flush = v.fl; dispatch_valid = v.dv; dispatch_op = v.op;
        dispatch_vj = v.vj; dispatch_qj_rdy = v.jr; dispatch_qj = v.qj;
        dispatch_vk = v.vk; dispatch_qk_rdy = v.kr; dispatch_qk = v.qk;
        dispatch_dest = v.dest; dispatch_pc = v.pc; dispatch_imm = v.imm;
        cdb_valid = v.cv; cdb_tag = v.ct; cdb_value = v.cval;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_full();
        foreach (ms[i]) if (!ms[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: decide issue and dispatch from the pre-edge snapshot, then apply them.
    task automatic m_step();
        slot_t old[8];
        int sel, fr;
        if (rst) begin
            foreach (ms[i]) ms[i].busy = 1'b0;
            m_iv = 1'b0; m_op = '0; m_rs = '0; m_rt = '0; m_pc = '0; m_imm = '0; m_dest = '0;
            return;
        end
        if (!rdy) return;
        if (flush) begin
            foreach (ms[i]) ms[i].busy = 1'b0;
            m_iv = 1'b0;
            return;
        end
        old = ms;
        sel = -1;
        fr = -1;
        for (int i = 0; i < 8; i++) begin
            if (sel < 0 && old[i].busy && old[i].rj && old[i].rk) sel = i;
            if (fr < 0 && !old[i].busy) fr = i;
        end
        m_iv = sel >= 0;
        if (sel >= 0) begin
            m_op = old[sel].op; m_rs = old[sel].vj; m_rt = old[sel].vk;
            m_pc = old[sel].pc; m_imm = old[sel].imm; m_dest = old[sel].dest;
            ms[sel].busy = 1'b0;
        end
        if (cdb_valid)
            for (int i = 0; i < 8; i++) begin
                if (old[i].busy && !old[i].rj && old[i].qj == cdb_tag) begin ms[i].vj = cdb_value; ms[i].rj = 1'b1; end
                if (old[i].busy && !old[i].rk && old[i].qk == cdb_tag) begin ms[i].vk = cdb_value; ms[i].rk = 1'b1; end
            end
        if (dispatch_valid && fr >= 0) begin
            ms[fr].busy = 1'b1; ms[fr].op = dispatch_op; ms[fr].pc = dispatch_pc;
            ms[fr].imm = dispatch_imm; ms[fr].dest = dispatch_dest;
            ms[fr].qj = dispatch_qj; ms[fr].qk = dispatch_qk;
            ms[fr].rj = dispatch_qj_rdy || (cdb_valid && cdb_tag == dispatch_qj);
            ms[fr].rk = dispatch_qk_rdy || (cdb_valid && cdb_tag == dispatch_qk);
            ms[fr].vj = (!dispatch_qj_rdy && cdb_valid && cdb_tag == dispatch_qj) ? cdb_value : dispatch_vj;
            ms[fr].vk = (!dispatch_qk_rdy && cdb_valid && cdb_tag == dispatch_qk) ? cdb_value : dispatch_vk;
        end
    endtask

    initial begin
        vec_t v;
        t[0]  = disp(6'h13, 5, 1, 0, 0, 1, 0, 1, 32'h100, 7);
        t[1]  = ex(idle(), 6'h13, 5, 0, 32'h100, 7, 1);
        t[2]  = disp(6'h01, 0, 0, 3, 2, 1, 0, 2, 32'h104, 0);
        t[3]  = idle();
        t[4]  = bcast(idle(), 3, 32'h10);
        t[5]  = ex(idle(), 6'h01, 32'h10, 2, 32'h104, 0, 2);
        t[6]  = bcast(disp(6'h02, 32'h11, 1, 0, 0, 0, 2, 3, 32'h108, 0), 2, 32'hAB);
        t[7]  = ex(idle(), 6'h02, 32'h11, 32'hAB, 32'h108, 0, 3);
        t[8]  = idle();
        t[9]  = bcast(disp(6'h04, 32'h22, 1, 5, 32'h33, 1, 0, 4, 32'h10c, 0), 5, 32'h99);
        t[10] = ex(idle(), 6'h04, 32'h22, 32'h33, 32'h10c, 0, 4);
        t[11] = disp(6'h05, 1, 1, 0, 2, 1, 0, 5, 32'h110, 32'hFFFF_FFFC);
        t[12] = ex(disp(6'h06, 3, 1, 0, 4, 1, 0, 6, 32'h114, 8), 6'h05, 1, 2, 32'h110, 32'hFFFF_FFFC, 5);
        t[13] = ex(idle(), 6'h06, 3, 4, 32'h114, 8, 6);
        t[14] = idle();
        t[15] = disp(6'h07, 7, 1, 0, 8, 1, 0, 7, 32'h118, 0);
        t[15].rdy = 1'b0;
        t[16] = disp(6'h08, 0, 0, 6, 9, 1, 0, 8, 32'h11c, 0);
        t[17] = bcast(idle(), 6, 32'h66);
        t[17].rdy = 1'b0;
        t[18] = idle();
        t[19] = idle();
        t[20] = idle();
        t[20].fl = 1'b1;

        rst = 1'b1;
        drive(idle());
        tick();
        tick();
        rst = 1'b0;
        chk("rst_full", full, 0);
        chk("rst_iv", issue_valid, 0);
        chk("rst_data", {issue_op, issue_rs, issue_rt, issue_dest}, 0);
        chk("rst_pcimm", {issue_pc, issue_imm}, 0);

        for (int i = 0; i < 21; i++) begin
            drive(t[i]);
            chk($sformatf("v%0d_full", i), full, t[i].e_full);
            tick();
            chk($sformatf("v%0d_iv", i), issue_valid, t[i].e_iv);
            if (t[i].e_iv) begin
                chk($sformatf("v%0d_op", i), issue_op, t[i].e_op);
                chk($sformatf("v%0d_rs", i), issue_rs, t[i].e_rs);
                chk($sformatf("v%0d_rt", i), issue_rt, t[i].e_rt);
                chk($sformatf("v%0d_pc", i), issue_pc, t[i].e_pc);
                chk($sformatf("v%0d_imm", i), issue_imm, t[i].e_imm);
                chk($sformatf("v%0d_dest", i), issue_dest, t[i].e_dest);
            end
        end

        // Fill all slots waiting on tag 9, then drain in index order.
        for (int i = 0; i < 8; i++) begin
            drive(disp(6'(i), 0, 0, 9, 32'(i), 1, 0, 4'(i), 32'(i * 4), 32'(i)));
            chk("fill_full", full, 0);
            tick();
            chk("fill_iv", issue_valid, 0);
        end
        drive(disp(6'h3F, 1, 1, 0, 1, 1, 0, 15, 0, 0));
        chk("full_set", full, 1);
        tick();
        chk("ninth_ignored", issue_valid, 0);
        drive(bcast(idle(), 9, 32'h900));
        chk("full_wake", full, 1);
        tick();
        chk("wake_no_issue", issue_valid, 0);
        for (int i = 0; i < 8; i++) begin
            drive(idle());
            chk($sformatf("drain%0d_full", i), full, i == 0);
            tick();
            chk($sformatf("drain%0d_iv", i), issue_valid, 1);
            chk($sformatf("drain%0d_dest", i), issue_dest, i);
            chk($sformatf("drain%0d_rs", i), issue_rs, 32'h900);
            chk($sformatf("drain%0d_rt", i), issue_rt, i);
        end
        drive(idle());
        tick();
        chk("drain_done", issue_valid, 0);

        // Flush with 5 busy slots and a simultaneous ready dispatch.
        for (int i = 0; i < 5; i++) begin
            drive(disp(6'h09, 0, 0, 10, 0, 1, 0, 4'(i), 0, 0));
            tick();
        end
        v = disp(6'h0A, 1, 1, 0, 1, 1, 0, 12, 0, 0);
        v.fl = 1'b1;
        drive(v);
        tick();
        chk("flush_full", full, 0);
        chk("flush_iv", issue_valid, 0);
        drive(bcast(idle(), 10, 32'h1));
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(idle());
            chk($sformatf("post_flush%0d_iv", i), issue_valid, 0);
        end

        // Reset mid-operation with rdy low overrides everything.
        for (int i = 0; i < 3; i++) begin
            drive(disp(6'h0B, 0, 0, 11, 0, 1, 0, 4'(i + 1), 0, 0));
            tick();
        end
        drive(disp(6'h0C, 32'h55, 1, 0, 32'h66, 1, 0, 4, 32'h200, 3));
        tick();
        drive(idle());
        tick();
        chk("pre_rst_iv", issue_valid, 1);
        chk("pre_rst_rs", issue_rs, 32'h55);
        v = disp(6'h0D, 1, 1, 0, 1, 1, 0, 5, 0, 0);
        v.rdy = 1'b0;
        v.fl = 1'b1;
        drive(v);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_iv", issue_valid, 0);
        chk("mid_rst_data", {issue_op, issue_rs, issue_rt, issue_dest}, 0);
        chk("mid_rst_pcimm", {issue_pc, issue_imm}, 0);
        chk("mid_rst_full", full, 0);
        drive(bcast(idle(), 11, 32'h7));
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(idle());
            chk($sformatf("post_rst%0d_iv", i), issue_valid, 0);
        end

        // Random lockstep against the model.
        rst = 1'b1;
        drive(idle());
        @(posedge clk);
        m_step();
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = $urandom_range(0, 199) == 0;
            rdy = $urandom_range(0, 9) != 0;
            flush = $urandom_range(0, 39) == 0;
            dispatch_valid = $urandom_range(0, 9) < 6;
            dispatch_op = 6'($urandom);
            dispatch_vj = $urandom;
            dispatch_vk = $urandom;
            dispatch_qj = 4'($urandom_range(0, 3));
            dispatch_qk = 4'($urandom_range(0, 3));
            dispatch_qj_rdy = $urandom_range(0, 1) == 1;
            dispatch_qk_rdy = $urandom_range(0, 1) == 1;
            dispatch_pc = $urandom;
            dispatch_imm = $urandom;
            dispatch_dest = 4'($urandom);
            cdb_valid = $urandom_range(0, 9) < 4;
            cdb_tag = 4'($urandom_range(0, 3));
            cdb_value = $urandom;
            chk("rnd_full", full, m_full());
            @(posedge clk);
            m_step();
            #1;
            chk("rnd_iv", issue_valid, m_iv);
            if (m_iv) begin
                chk("rnd_op", issue_op, m_op);
                chk("rnd_rs", issue_rs, m_rs);
                chk("rnd_rt", issue_rt, m_rt);
                chk("rnd_pc", issue_pc, m_pc);
                chk("rnd_imm", issue_imm, m_imm);
                chk("rnd_dest", issue_dest, m_dest);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
